timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
Runtime-programmable timer controller that sequences a prescaled up-counter for robot timebases (PWM periods, control-loop ticks, timeouts). Software and other RTL load the period, prescaler and mode through a valid/ready config port, then start and stop the timer. The block emits a one-cycle tick at each period wrap and a sticky done flag in one-shot mode. Period and prescaler are set at run time, not elaborated as parameters.

Parameters:
NBITS, 16, width of main count and period
PRESC_BITS, 8, width of prescaler divider value

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
cfg_valid  in  1  config offer
cfg_ready  out  1  config can be accepted
cfg_period  in  NBITS  period in count steps; 0 is invalid
cfg_presc  in  PRESC_BITS  count advances every cfg_presc+1 cycles
cfg_mode  in  1  0 = one-shot, 1 = periodic
start  in  1  start request, level-sampled
stop  in  1  stop request, level-sampled
count  out  NBITS  current count
tick  out  1  one-cycle pulse on period wrap
done  out  1  sticky one-shot completion flag
busy  out  1  high while in RUN

Behaviour:
- Reset (rst=0, async): state IDLE; count=0, tick=0, done=0, busy=0, cfg_ready=1; period_reg=0, presc_reg=0, mode_reg=0, presc_cnt=0.
- States: IDLE, RUN, DONE. busy = (state==RUN). cfg_ready = (state!=RUN), combinational from state.
- Config accept: cfg_valid && cfg_ready at an edge loads period_reg, presc_reg and mode_reg. In DONE, an accept also clears done and moves to IDLE. cfg_valid in RUN is ignored and holds no pending request.
- Start: in IDLE or DONE, start=1 with effective period != 0 enters RUN at that edge. count=0, presc_cnt=0, done=0. The effective period is cfg_period if a config is accepted in the same cycle, otherwise period_reg. Start with effective period 0 is ignored, state unchanged. Start in RUN is ignored.
- Stop has priority over start and over count advance. In RUN, stop causes RUN->IDLE, count holds its value, and tick=0. In DONE, stop causes DONE->IDLE and clears done. In IDLE, stop has no effect.
- RUN advance: each cycle, if presc_cnt==presc_reg then presc_cnt<=0 and advance, else presc_cnt+1. Widths are unsigned with no overflow; compares are at full width.
- On advance with count==period_reg-1, this is a wrap:
  - count<=0 and tick<=1 for exactly one cycle.
  - Periodic mode stays in RUN.
  - One-shot mode goes to DONE with done<=1.
- On advance without a wrap, count<=count+1.
- tick is 0 in all other cycles.
- Latency: start sampled at edge k gives busy=1 after edge k. The first increment is at edge k+presc+1. The first tick is at edge k+period*(presc+1).
- Period=1 ticks every presc+1 cycles with count always 0. presc=0 advances every cycle.
- Reset asserted mid-RUN returns immediately to reset values. No tick is generated.
- DONE holds count=0 and done=1 until start, stop or config accept.

Optional Feature:
Macro: TIMER_CTRL_CAPTURE_EN.
- Defined:
  - Adds ports cap_in (in, 1, async event), cap_value (out, NBITS) and cap_valid (out, 1).
  - cap_in passes through a 2-FF synchronizer and a rising-edge detector.
  - A detected edge while busy loads cap_value<=count and pulses cap_valid for one cycle. Edges outside RUN are ignored.
  - Latency from cap_in rise to cap_valid is 3 clk edges.
  - Reset values: cap_value=0, cap_valid=0, synchronizer=0.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 mid-RUN (period=5, presc=0) -> count=0, busy=0, done=0, tick=0 and cfg_ready=1 immediately, before the next edge.
- Periodic: cfg period=4, presc=2, mode=1, then start -> tick at edges k+12, k+24, k+36; count sequence 0,1,2,3 with each value held 3 cycles; busy stays 1.
- One-shot: period=3, presc=0, mode=0, start -> tick and done at edge k+3, state DONE, count=0. A second start clears done and re-runs.
- Boundaries:
  - start with period 0 -> stays IDLE.
  - start and stop in the same cycle -> stays IDLE.
  - cfg_valid in RUN -> cfg_ready=0 and period unchanged.
- Stop mid-run: period=10, presc=0, stop at count=6 -> IDLE, count holds 6, no tick. cfg+start in one cycle with period=2 -> tick every 2 cycles.
- Capture (macro on): period=100, presc=0, cap_in rises when count=20 -> cap_valid 3 edges later with cap_value=22. Edge while IDLE -> no cap_valid.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Configuration port of timer_ctrl: valid/ready offer of period, prescaler and mode.
// The master drives the offer; the slave (timer) returns cfg_ready.
interface timer_ctrl_if #(
  parameter int NBITS      = 16,
  parameter int PRESC_BITS = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [NBITS-1:0]      cfg_period;
  logic [PRESC_BITS-1:0] cfg_presc;
  logic                  cfg_mode;

  modport master (
    output cfg_valid, cfg_period, cfg_presc, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_presc, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/timer_ctrl.sv
// Runtime-programmable prescaled timer: tick on period wrap, sticky done in one-shot mode.
// Latency: busy one edge after start; first tick period*(presc+1) edges after start.
// Backpressure: cfg_ready low in RUN, offers there are dropped. TIMER_CTRL_CAPTURE_EN adds capture.
module timer_ctrl #(
  parameter int NBITS      = 16,
  parameter int PRESC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  timer_ctrl_if.slave      cfg,
  input  logic             start,
  input  logic             stop,
  output logic [NBITS-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             busy
`ifdef TIMER_CTRL_CAPTURE_EN
  ,
  input  logic             cap_in,
  output logic [NBITS-1:0] cap_value,
  output logic             cap_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [NBITS-1:0]      r_count;
  logic [NBITS-1:0]      r_period;
  logic [PRESC_BITS-1:0] r_presc;
  logic [PRESC_BITS-1:0] r_presc_cnt;
  logic                  r_mode;
  logic                  r_tick;
  logic                  r_done;

  logic                  w_cfg_acc;
  logic [NBITS-1:0]      w_eff_period;
  logic                  w_start_ok;

  assign busy          = (r_state == RUN);
  assign cfg.cfg_ready = (r_state != RUN);
  assign count         = r_count;
  assign tick          = r_tick;
  assign done          = r_done;

  assign w_cfg_acc    = cfg.cfg_valid && (r_state != RUN);
  // A config accepted in the same cycle supplies the period a start is judged against.
  assign w_eff_period = w_cfg_acc ? cfg.cfg_period : r_period;
  assign w_start_ok   = start && (w_eff_period != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_period    <= '0;
      r_presc     <= '0;
      r_presc_cnt <= '0;
      r_mode      <= 1'b0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_cfg_acc) begin
        r_period <= cfg.cfg_period;
        r_presc  <= cfg.cfg_presc;
        r_mode   <= cfg.cfg_mode;
      end
      case (r_state)
        IDLE: begin
          if (!stop && w_start_ok) begin
            r_state     <= RUN;
            r_count     <= '0;
            r_presc_cnt <= '0;
            r_done      <= 1'b0;
          end
        end
        DONE: begin
          if (stop) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else if (w_start_ok) begin
            r_state     <= RUN;
            r_count     <= '0;
            r_presc_cnt <= '0;
            r_done      <= 1'b0;
          end else if (w_cfg_acc) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (r_presc_cnt == r_presc) begin
            r_presc_cnt <= '0;
            if (r_count == (r_period - NBITS'(1))) begin
              r_count <= '0;
              r_tick  <= 1'b1;
              if (!r_mode) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_count <= r_count + NBITS'(1);
            end
          end else begin
            r_presc_cnt <= r_presc_cnt + PRESC_BITS'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TIMER_CTRL_CAPTURE_EN
  logic [1:0] r_cap_sync;
  logic       r_cap_prev;
  logic       w_cap_rise;

  // Two sync stages plus one edge register: cap_valid lands on the third edge after cap_in rises.
  assign w_cap_rise = r_cap_sync[1] && !r_cap_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap_sync <= 2'b00;
      r_cap_prev <= 1'b0;
      cap_value  <= '0;
      cap_valid  <= 1'b0;
    end else begin
      r_cap_sync <= {r_cap_sync[0], cap_in};
      r_cap_prev <= r_cap_sync[1];
      cap_valid  <= 1'b0;
      if (w_cap_rise && busy) begin
        cap_value <= r_count;
        cap_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
